// File: rtl/mmio_axi_lite_master_if.sv
// AXI-lite bus bundle between the MMIO bridge (master) and a peripheral (slave).
interface mmio_axi_lite_master_if #(
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 64
);
    logic [ADDR_WIDTH-1:0]   awaddr;
    logic                    awvalid;
    logic                    awready;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] wstrb;
    logic                    wvalid;
    logic                    wready;
    logic [1:0]              bresp;
    logic                    bvalid;
    logic                    bready;
    logic [ADDR_WIDTH-1:0]   araddr;
    logic                    arvalid;
    logic                    arready;
    logic [DATA_WIDTH-1:0]   rdata;
    logic [1:0]              rresp;
    logic                    rvalid;
    logic                    rready;

    modport master (
        output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport slave (
        input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/mmio_axi_lite_master.sv
// Single-outstanding CPU MMIO port to AXI-lite master bridge.
// Optional slave-response watchdog is built when MMIO_TIMEOUT_EN is defined.
module mmio_axi_lite_master #(
    parameter int ADDR_WIDTH     = 64,
    parameter int DATA_WIDTH     = 64,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_we,
    input  logic [ADDR_WIDTH-1:0]   req_addr,
    input  logic [DATA_WIDTH-1:0]   req_wdata,
    input  logic [DATA_WIDTH/8-1:0] req_wmask,
    output logic                    resp_valid,
    output logic [DATA_WIDTH-1:0]   resp_rdata,
    output logic                    resp_err,
    mmio_axi_lite_master_if.master  axi
);

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        WRESP,
        RADDR,
        RDATA,
        RESP
    } state_t;

    state_t state;
    state_t state_next;

    logic [ADDR_WIDTH-1:0]   awaddr_q;
    logic [ADDR_WIDTH-1:0]   araddr_q;
    logic [DATA_WIDTH-1:0]   wdata_q;
    logic [DATA_WIDTH/8-1:0] wstrb_q;
    logic                    awvalid_q;
    logic                    wvalid_q;
    logic                    arvalid_q;
    logic [DATA_WIDTH-1:0]   resp_rdata_q;
    logic                    resp_err_q;

    logic accept;
    logic aw_done;
    logic w_done;
    logic timeout_hit;

    assign accept  = (state == IDLE) && req_valid;
    // A channel counts as finished once its valid has dropped or is handshaking now.
    assign aw_done = !awvalid_q || axi.awready;
    assign w_done  = !wvalid_q  || axi.wready;

`ifdef MMIO_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;

    logic [CNT_W-1:0] timeout_cnt;
    logic             busy;
    logic             resp_arrival;

    assign busy         = (state == WRITE) || (state == WRESP) ||
                          (state == RADDR) || (state == RDATA);
    // A genuine slave response in the limit cycle beats the forced error.
    assign resp_arrival = ((state == WRESP) && axi.bvalid) ||
                          ((state == RDATA) && axi.rvalid);
    assign timeout_hit  = busy && !resp_arrival &&
                          (timeout_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (!rstn) begin
            timeout_cnt <= '0;
        end else if (accept) begin
            timeout_cnt <= '0;
        end else if (busy) begin
            timeout_cnt <= timeout_cnt + 1'b1;
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = req_we ? WRITE : RADDR;
            WRITE:   if (aw_done && w_done) state_next = WRESP;
            WRESP:   if (axi.bvalid) state_next = RESP;
            RADDR:   if (axi.arready) state_next = RDATA;
            RDATA:   if (axi.rvalid) state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if (timeout_hit) begin
            state_next = RESP;
        end
    end

    always_comb begin
        req_ready  = (state == IDLE);
        resp_valid = (state == RESP);
        axi.bready = (state == WRESP);
        axi.rready = (state == RDATA);
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            awaddr_q     <= '0;
            araddr_q     <= '0;
            wdata_q      <= '0;
            wstrb_q      <= '0;
            awvalid_q    <= 1'b0;
            wvalid_q     <= 1'b0;
            arvalid_q    <= 1'b0;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (req_we) begin
                            awaddr_q  <= req_addr;
                            wdata_q   <= req_wdata;
                            wstrb_q   <= req_wmask;
                            awvalid_q <= 1'b1;
                            wvalid_q  <= 1'b1;
                        end else begin
                            araddr_q  <= req_addr;
                            arvalid_q <= 1'b1;
                        end
                    end
                end
                WRITE: begin
                    if (awvalid_q && axi.awready) awvalid_q <= 1'b0;
                    if (wvalid_q && axi.wready)   wvalid_q  <= 1'b0;
                end
                WRESP: begin
                    if (axi.bvalid) begin
                        resp_rdata_q <= '0;
                        resp_err_q   <= (axi.bresp != 2'b00);
                    end
                end
                RADDR: begin
                    if (axi.arready) arvalid_q <= 1'b0;
                end
                RDATA: begin
                    if (axi.rvalid) begin
                        resp_rdata_q <= axi.rdata;
                        resp_err_q   <= (axi.rresp != 2'b00);
                    end
                end
                default: ;
            endcase
            if (timeout_hit) begin
                awvalid_q    <= 1'b0;
                wvalid_q     <= 1'b0;
                arvalid_q    <= 1'b0;
                resp_rdata_q <= '0;
                resp_err_q   <= 1'b1;
            end
        end
    end

    assign axi.awaddr  = awaddr_q;
    assign axi.awvalid = awvalid_q;
    assign axi.wdata   = wdata_q;
    assign axi.wstrb   = wstrb_q;
    assign axi.wvalid  = wvalid_q;
    assign axi.araddr  = araddr_q;
    assign axi.arvalid = arvalid_q;
    assign resp_rdata  = resp_rdata_q;
    assign resp_err    = resp_err_q;

endmodule

// File: doc/mmio_axi_lite_master.md
Name: mmio_axi_lite_master

Overview:
- Bridges the CPU's single-outstanding MMIO load/store port to an AXI-lite master interface.
- Drives the slave side of the UART AXI-lite wrapper and other MMIO peripherals, directly upstream of them.
- Converts one request into one AXI-lite read or write transaction, then returns exactly one response (data plus error flag) to the CPU.
- 64-bit address and data throughout; peripheral-specific narrowing is done downstream.

Parameters:
- ADDR_WIDTH, 64, width of request address and AXI araddr/awaddr.
- DATA_WIDTH, 64, width of request data and AXI rdata/wdata; strobe width is DATA_WIDTH/8.
- TIMEOUT_CYCLES, 1024, cycles to wait for a slave response before forcing an error. Used only with MMIO_TIMEOUT_EN.

Ports:
- clk  in  1  single clock, rising edge.
- rstn  in  1  synchronous active-low reset.
- req_valid  in  1  CPU request valid.
- req_ready  out  1  bridge can accept a request.
- req_we  in  1  1 = store, 0 = load.
- req_addr  in  ADDR_WIDTH  byte address.
- req_wdata  in  DATA_WIDTH  store data.
- req_wmask  in  DATA_WIDTH/8  store byte enables.
- resp_valid  out  1  one-cycle response pulse.
- resp_rdata  out  DATA_WIDTH  load data; 0 for stores.
- resp_err  out  1  slave returned non-OKAY, or timeout occurred.
- awaddr  out  ADDR_WIDTH
- awvalid  out  1
- awready  in  1
- wdata  out  DATA_WIDTH
- wstrb  out  DATA_WIDTH/8
- wvalid  out  1
- wready  in  1
- bresp  in  2
- bvalid  in  1
- bready  out  1
- araddr  out  ADDR_WIDTH
- arvalid  out  1
- arready  in  1
- rdata  in  DATA_WIDTH
- rresp  in  2
- rvalid  in  1
- rready  out  1

Behaviour:
- Reset (rstn=0 at a rising clk edge):
  - state = IDLE.
  - All AXI valid/ready outputs = 0; resp_valid = 0; resp_err = 0; resp_rdata = 0.
  - awaddr, araddr, wdata and wstrb = 0.
  - req_ready = 1 from the first cycle after reset is released.
- States: IDLE, WRITE, WRESP, RADDR, RDATA, RESP.
- IDLE:
  - req_ready = 1; it is 0 in every other state.
  - On req_valid & req_ready, register addr, wdata and wmask.
  - req_we=1: go to WRITE with awvalid=1 and wvalid=1 in the next cycle. wstrb = req_wmask unchanged; a zero mask is still issued.
  - req_we=0: go to RADDR with arvalid=1 in the next cycle.
- WRITE:
  - awvalid drops the cycle after its own handshake (awvalid&awready). wvalid likewise drops the cycle after wvalid&wready.
  - The two handshakes may complete in either order or in the same cycle.
  - Payload stays stable while its valid is high.
  - When both handshakes are done, go to WRESP.
- WRESP:
  - bready = 1.
  - On bvalid: latch err = (bresp != 2'b00), set resp_rdata = 0, go to RESP.
- RADDR:
  - On arvalid&arready, drop arvalid and go to RDATA.
- RDATA:
  - rready = 1.
  - On rvalid: latch resp_rdata = rdata and err = (rresp != 2'b00), go to RESP.
- RESP:
  - resp_valid = 1 for exactly one cycle, then IDLE.
  - resp_rdata and resp_err hold their values until the next response.
- Latency with a zero-wait slave:
  - Store: accepted at cycle 0; awvalid/wvalid at cycle 1; bvalid at cycle 2; resp_valid at cycle 3.
  - Load: accepted at cycle 0; arvalid at cycle 1; rvalid at cycle 2; resp_valid at cycle 3.
- A bvalid or rvalid arriving in a state that does not expect it is ignored; bready and rready are low in those states.
- Backpressure: valids are held indefinitely while the slave keeps its ready low (without MMIO_TIMEOUT_EN).
- Reset mid-transaction: valids drop on the reset edge and no response is produced. The slave is also reset by the same rstn.
- req_valid is ignored outside IDLE. The CPU holds its request until it sees req_ready.

Optional Feature:
- Macro: MMIO_TIMEOUT_EN.
- When defined:
  - A counter clears on entering WRITE or RADDR and increments every cycle in WRITE, WRESP, RADDR and RDATA.
  - On reaching TIMEOUT_CYCLES-1, all AXI valid/ready outputs drop, resp_err=1, resp_rdata=0, and state goes to RESP.
- When undefined: no counter is built and the bridge waits forever.

Test Plan:
- Zero-wait store: addr 0x1000_0004, wdata 0xA5, wmask 0x01; slave gives immediate ready and bresp=00. Expect awaddr=0x1000_0004, wstrb=0x01, resp_valid at cycle 3, resp_err=0, resp_rdata=0.
- Load with 3-cycle arready delay: rdata 0x0000_0000_0000_0060, rresp=00. Expect resp_rdata=0x60 and resp_valid exactly 1 cycle after the rvalid cycle plus one.
- Split write handshake: wready at cycle 1, awready at cycle 4. Expect wvalid to drop at cycle 2, awvalid to drop at cycle 5, bready to rise at cycle 5, then one response.
- Error response: slave returns rresp=2'b10 with rdata 0xDEAD. Expect resp_err=1 and resp_rdata=0xDEAD.
- Reset mid-read: rstn=0 while in RDATA. Expect arvalid=rready=resp_valid=0 after the edge and req_ready=1 after release. A following load completes normally.
- MMIO_TIMEOUT_EN with TIMEOUT_CYCLES=16, slave never asserts arready. Expect arvalid to drop and resp_valid=1 with resp_err=1 exactly 17 cycles after acceptance.
